// File: rtl/rv64b_ise_pkg.sv
// Shared definitions for the RV64 bitmanip ISE datapath: op codes, payload struct
// and the op legality check used by both the ALU and the arbiter.
package rv64b_ise_pkg;

    localparam int OP_W      = 3;
    localparam int NUM_OPS   = 5;
    localparam int XLEN      = 64;
    localparam int N_REQ     = 2;
    localparam int TAG_W_DEF = 4;
    localparam int CNT_W_DEF = 32;

    localparam logic [OP_W-1:0] OP_RORIW = 3'd0;
    localparam logic [OP_W-1:0] OP_RORI  = 3'd1;
    localparam logic [OP_W-1:0] OP_XNOR  = 3'd2;
    localparam logic [OP_W-1:0] OP_PACK  = 3'd3;
    localparam logic [OP_W-1:0] OP_PACKU = 3'd4;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [5:0]      imm;
    } ise_req_t;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return (op <= OP_PACKU);
    endfunction

endpackage

// File: rtl/rv64b_ise_arb_if.sv
// Bundle of both requester handshakes and the result channel of the ISE arbiter.
// master = requesters/consumer side, slave = arbiter side.
interface rv64b_ise_arb_if #(
    parameter int TAG_W = rv64b_ise_pkg::TAG_W_DEF,
    parameter int CNT_W = rv64b_ise_pkg::CNT_W_DEF
) ();
    import rv64b_ise_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [OP_W-1:0]   req0_op;
    logic [XLEN-1:0]   req0_rs1;
    logic [XLEN-1:0]   req0_rs2;
    logic [5:0]        req0_imm;
    logic [TAG_W-1:0]  req0_tag;

    logic              req1_valid;
    logic              req1_ready;
    logic [OP_W-1:0]   req1_op;
    logic [XLEN-1:0]   req1_rs1;
    logic [XLEN-1:0]   req1_rs2;
    logic [5:0]        req1_imm;
    logic [TAG_W-1:0]  req1_tag;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [TAG_W-1:0]  rsp_tag;
    logic [XLEN-1:0]   rsp_rd;
    logic              rsp_err;
    logic [CNT_W-1:0]  ops_issued;

    modport master (
        output req0_valid, req0_op, req0_rs1, req0_rs2, req0_imm, req0_tag,
        input  req0_ready,
        output req1_valid, req1_op, req1_rs1, req1_rs2, req1_imm, req1_tag,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_tag, rsp_rd, rsp_err, ops_issued,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_op, req0_rs1, req0_rs2, req0_imm, req0_tag,
        output req0_ready,
        input  req1_valid, req1_op, req1_rs1, req1_rs2, req1_imm, req1_tag,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_tag, rsp_rd, rsp_err, ops_issued,
        input  rsp_ready
    );

endinterface

// File: rtl/rv64b_ise_alu.sv
// Combinational bitmanip datapath: log-shifter rotates, xnor, pack/packu,
// one-hot decoded AND-OR result mux. Illegal ops yield rd=0 with err set.
module rv64b_ise_alu
    import rv64b_ise_pkg::*;
(
    input  logic [OP_W-1:0] op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [5:0]      imm_i,
    output logic [XLEN-1:0] rd_o,
    output logic            err_o
);

    logic [NUM_OPS-1:0] sel;
    logic [31:0]        rot32;
    logic [XLEN-1:0]    rot64;
    logic [XLEN-1:0]    res_roriw;
    logic [XLEN-1:0]    res_xnor;
    logic [XLEN-1:0]    res_pack;
    logic [XLEN-1:0]    res_packu;

    generate
        for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_dec
            assign sel[gi] = (op_i == OP_W'(gi));
        end
    endgenerate

    // Each stage rotates by a fixed power of two when its amount bit is set.
    always_comb begin
        rot32 = rs1_i[31:0];
        for (int i = 0; i < 5; i++) begin
            if (imm_i[i]) begin
                rot32 = (rot32 >> (1 << i)) | (rot32 << (32 - (1 << i)));
            end
        end
        rot64 = rs1_i;
        for (int i = 0; i < 6; i++) begin
            if (imm_i[i]) begin
                rot64 = (rot64 >> (1 << i)) | (rot64 << (64 - (1 << i)));
            end
        end
    end

    assign res_roriw = {{32{rot32[31]}}, rot32};
    assign res_xnor  = rs1_i ^ ~rs2_i;
    assign res_pack  = {rs2_i[31:0], rs1_i[31:0]};
    assign res_packu = {rs2_i[63:32], rs1_i[63:32]};

    assign rd_o = ({XLEN{sel[0]}} & res_roriw)
                | ({XLEN{sel[1]}} & rot64)
                | ({XLEN{sel[2]}} & res_xnor)
                | ({XLEN{sel[3]}} & res_pack)
                | ({XLEN{sel[4]}} & res_packu);

    assign err_o = !op_legal(op_i);

endmodule

// File: rtl/rv64b_ise_arb.sv
// Two-port round-robin arbiter in front of the shared ISE ALU, with a one-deep
// result register that supports drain-and-accept in the same cycle.
module rv64b_ise_arb
    import rv64b_ise_pkg::*;
#(
    parameter int TAG_W = TAG_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic           g_clk,
    input  logic           g_rst,
    rv64b_ise_arb_if.slave bus
);

    logic [N_REQ-1:0] valid;
    logic [N_REQ-1:0] ready;
    ise_req_t         req_pl  [N_REQ];
    logic [TAG_W-1:0] req_tag [N_REQ];

    logic             both_valid;
    logic             any_valid;
    logic             gnt_idx;
    logic             can_load;
    logic             accept;
    ise_req_t         gnt_pl;
    logic [XLEN-1:0]  alu_rd;
    logic             alu_err;

    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q,    rsp_id_d;
    logic [TAG_W-1:0] rsp_tag_q,   rsp_tag_d;
    logic [XLEN-1:0]  rsp_rd_q,    rsp_rd_d;
    logic             rsp_err_q,   rsp_err_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             rr_ptr_q,    rr_ptr_d;

    assign valid      = {bus.req1_valid, bus.req0_valid};
    assign req_pl[0]  = '{op: bus.req0_op, rs1: bus.req0_rs1, rs2: bus.req0_rs2, imm: bus.req0_imm};
    assign req_pl[1]  = '{op: bus.req1_op, rs1: bus.req1_rs1, rs2: bus.req1_rs2, imm: bus.req1_imm};
    assign req_tag[0] = bus.req0_tag;
    assign req_tag[1] = bus.req1_tag;

    // rr_ptr only matters under contention; a lone requester always wins.
    assign both_valid = &valid;
    assign any_valid  = |valid;
    assign gnt_idx    = both_valid ? rr_ptr_q : valid[1];
    assign can_load   = !rsp_valid_q || bus.rsp_ready;
    assign accept     = any_valid && can_load && !g_rst;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign ready[gi] = accept && (gnt_idx == 1'(gi));
        end
    endgenerate

    assign bus.req0_ready = ready[0];
    assign bus.req1_ready = ready[1];

    assign gnt_pl = req_pl[gnt_idx];

    rv64b_ise_alu u_alu (
        .op_i  (gnt_pl.op),
        .rs1_i (gnt_pl.rs1),
        .rs2_i (gnt_pl.rs2),
        .imm_i (gnt_pl.imm),
        .rd_o  (alu_rd),
        .err_o (alu_err)
    );

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_rd_d    = rsp_rd_q;
        rsp_err_d   = rsp_err_q;
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = gnt_idx;
            rsp_tag_d   = req_tag[gnt_idx];
            rsp_rd_d    = alu_rd;
            rsp_err_d   = alu_err;
            cnt_d       = cnt_q + CNT_W'(1);
            if (both_valid) begin
                rr_ptr_d = ~gnt_idx;
            end
        end else if (bus.rsp_ready) begin
            // Drain only: payload keeps its last value.
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_tag_q   <= '0;
            rsp_rd_q    <= '0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
            rr_ptr_q    <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_rd_q    <= rsp_rd_d;
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_tag    = rsp_tag_q;
    assign bus.rsp_rd     = rsp_rd_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.ops_issued = cnt_q;

endmodule
